// File: rtl/tick_sched_pkg.sv
// Shared definitions for the tick scheduler.
//   - default channel count, counter width and reset divisor
//   - channel-index width helper (never narrower than one bit)
//   - per-channel state encoding
package tick_sched_pkg;

    localparam int unsigned NCH_DEFAULT = 4;
    localparam int unsigned CW_DEFAULT  = 16;
    // 1 kHz tick from a 50 MHz clk_in
    localparam int unsigned DEFAULT_DIV = 50000;

    function automatic int unsigned chan_idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned CHW = chan_idx_width(NCH_DEFAULT);

    typedef enum logic {
        StStop = 1'b0,
        StRun  = 1'b1
    } chan_state_e;

endpackage

// File: rtl/tick_chan.sv
// One scheduler channel: STOP/RUN state, period counter, active and pending
// divisor, registered tick strobe and square-wave toggle.
// Ports:
//   clk_in, rst     clock, asynchronous active-high reset
//   run_req         1 = run, 0 = stop
//   sync_start      realign phase (counter and sq cleared) when running
//   wr_en, wr_div   accepted divisor write targeted at this channel
//   tick            one-cycle strobe per divisor period
//   sq              toggles on every tick
//   running         channel is in RUN
module tick_chan #(
    parameter int unsigned CW          = tick_sched_pkg::CW_DEFAULT,
    parameter int unsigned DEFAULT_DIV = tick_sched_pkg::DEFAULT_DIV
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic          run_req,
    input  logic          sync_start,
    input  logic          wr_en,
    input  logic [CW-1:0] wr_div,
    output logic          tick,
    output logic          sq,
    output logic          running
);
    import tick_sched_pkg::*;

    chan_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] div_act_q, div_act_d;
    logic [CW-1:0] div_pend_q, div_pend_d;
    logic          pend_valid_q, pend_valid_d;
    logic          tick_q, tick_d;
    logic          sq_q, sq_d;
    logic          wrap;

    // div_act is never zero, so the subtraction cannot underflow
    assign wrap = (cnt_q == div_act_q - CW'(1));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        div_act_d    = div_act_q;
        div_pend_d   = div_pend_q;
        pend_valid_d = pend_valid_q;
        tick_d       = 1'b0;
        sq_d         = sq_q;

        case (state_q)
            StStop: begin
                cnt_d = '0;
                sq_d  = 1'b0;
                // Nothing is running, so a new divisor takes effect at once
                if (wr_en) begin
                    div_act_d = wr_div;
                end
                if (run_req) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!run_req) begin
                    // Stop beats sync and wrap; pending (or same-cycle) divisor lands now
                    state_d      = StStop;
                    cnt_d        = '0;
                    sq_d         = 1'b0;
                    pend_valid_d = 1'b0;
                    if (pend_valid_q) begin
                        div_act_d = div_pend_q;
                    end
                    if (wr_en) begin
                        div_act_d = wr_div;
                    end
                end else begin
                    if (sync_start) begin
                        cnt_d = '0;
                        sq_d  = 1'b0;
                    end else if (wrap) begin
                        cnt_d  = '0;
                        tick_d = 1'b1;
                        sq_d   = ~sq_q;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    // A period boundary consumes the value pending before this edge
                    if ((sync_start || wrap) && pend_valid_q) begin
                        div_act_d    = div_pend_q;
                        pend_valid_d = 1'b0;
                    end
                    // A write landing on a boundary waits for the next one
                    if (wr_en) begin
                        div_pend_d   = wr_div;
                        pend_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StStop;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q      <= StStop;
            cnt_q        <= '0;
            div_act_q    <= CW'(DEFAULT_DIV);
            div_pend_q   <= '0;
            pend_valid_q <= 1'b0;
            tick_q       <= 1'b0;
            sq_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_act_q    <= div_act_d;
            div_pend_q   <= div_pend_d;
            pend_valid_q <= pend_valid_d;
            tick_q       <= tick_d;
            sq_q         <= sq_d;
        end
    end

    assign tick    = tick_q;
    assign sq      = sq_q;
    assign running = (state_q == StRun);

endmodule

// File: rtl/tick_sched.sv
// Multi-channel tick/strobe scheduler. Produces per-channel clock-enable
// strobes and 50%-duty toggles from clk_in with run-time programmable divisors.
// Ports:
//   clk_in, rst              clock, asynchronous active-high reset
//   run_req[NCH]             per-channel run level
//   sync_start               phase-align all running channels
//   cfg_wr, cfg_ch, cfg_div  divisor write request
//   cfg_ack, cfg_err         one-cycle write accepted / rejected
//   tick[NCH], sq[NCH]       per-channel strobe and toggle
//   running[NCH]             per-channel RUN state
module tick_sched #(
    parameter int unsigned  NCH         = tick_sched_pkg::NCH_DEFAULT,
    parameter int unsigned  CW          = tick_sched_pkg::CW_DEFAULT,
    parameter int unsigned  DEFAULT_DIV = tick_sched_pkg::DEFAULT_DIV,
    localparam int unsigned CHW         = tick_sched_pkg::chan_idx_width(NCH)
) (
    input  logic           clk_in,
    input  logic           rst,
    input  logic [NCH-1:0] run_req,
    input  logic           sync_start,
    input  logic           cfg_wr,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [CW-1:0]  cfg_div,
    output logic           cfg_ack,
    output logic           cfg_err,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] sq,
    output logic [NCH-1:0] running
);
    logic           cfg_ack_q, cfg_ack_d;
    logic           cfg_err_q, cfg_err_d;
    logic           ch_valid;
    logic           div_valid;
    logic           accept;
    logic [NCH-1:0] chan_wr;

    always_comb begin
        ch_valid = 1'b0;
        chan_wr  = '0;
        // Matching against every real index also rejects cfg_ch >= NCH
        for (int unsigned i = 0; i < NCH; i++) begin
            if (cfg_ch == CHW'(i)) begin
                ch_valid = 1'b1;
            end
        end
        div_valid = (cfg_div != '0);
        accept    = cfg_wr && ch_valid && div_valid;
        for (int unsigned i = 0; i < NCH; i++) begin
            chan_wr[i] = accept && (cfg_ch == CHW'(i));
        end
        cfg_ack_d = accept;
        cfg_err_d = cfg_wr && !accept;
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cfg_ack_q <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_ack_q <= cfg_ack_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_ack = cfg_ack_q;
    assign cfg_err = cfg_err_q;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        tick_chan #(
            .CW          (CW),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk_in     (clk_in),
            .rst        (rst),
            .run_req    (run_req[g]),
            .sync_start (sync_start),
            .wr_en      (chan_wr[g]),
            .wr_div     (cfg_div),
            .tick       (tick[g]),
            .sq         (sq[g]),
            .running    (running[g])
        );
    end

endmodule
